// File: rtl/mul_arbiter_if.sv
// Bus bundle between the mul_arbiter, its two requesters and the multiplier core.
// Ports: req/a/b (requester -> arbiter), ack/done/res (arbiter -> requester), busy,
//        mul_start/mul_a/mul_b (arbiter -> core), mul_op (core -> arbiter).
// The arbiter side uses the slave modport; the environment (requesters + core) uses master.
interface mul_arbiter_if #(
  parameter int W = 8
);
  logic           req0;
  logic           req1;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic           ack0;
  logic           ack1;
  logic           done0;
  logic           done1;
  logic [2*W-1:0] res0;
  logic [2*W-1:0] res1;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_op;

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_op,
    input  ack0, ack1, done0, done1, res0, res1, busy, mul_start, mul_a, mul_b
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_op,
    output ack0, ack1, done0, done1, res0, res1, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency W x W multiplier core between two requesters.
// Latency: grant edge to done visible is LAT+1 edges; one product per LAT+2 cycles back-to-back.
// Backpressure: requests are only sampled in IDLE; a req raised while busy simply waits for the next IDLE.
//
// Ports: clk, rst (sync, active-high); bus (mul_arbiter_if.slave) carries the requester
// handshakes (req/a/b in, ack/done/res out), busy, and the core interface (mul_start/mul_a/mul_b out, mul_op in).
module mul_arbiter #(
  parameter int W   = 8,
  parameter int LAT = 9
) (
  input  logic          clk,
  input  logic          rst,
  mul_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LAT - 1);

  state_t         state, state_n;
  logic           last, last_n;      // requester granted most recently
  logic           owner, owner_n;    // requester owning the current operation
  logic [7:0]     cnt, cnt_n;
  logic           ack0_q, ack0_n;
  logic           ack1_q, ack1_n;
  logic           done0_q, done0_n;
  logic           done1_q, done1_n;
  logic           start_q, start_n;
  logic           busy_q, busy_n;
  logic [W-1:0]   mul_a_q, mul_a_n;
  logic [W-1:0]   mul_b_q, mul_b_n;
  logic [2*W-1:0] res0_q, res0_n;
  logic [2*W-1:0] res1_q, res1_n;

  logic gnt0, gnt1;

  // With both requesting, the one that was not served last wins.
  assign gnt0 = bus.req0 & (~bus.req1 | last);
  assign gnt1 = bus.req1 & (~bus.req0 | ~last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      cnt     <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      done0_q <= done0_n;
      done1_q <= done1_n;
      start_q <= start_n;
      busy_q  <= busy_n;
      mul_a_q <= mul_a_n;
      mul_b_q <= mul_b_n;
      res0_q  <= res0_n;
      res1_q  <= res1_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    cnt_n   = cnt;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    start_n = 1'b0;
    mul_a_n = mul_a_q;
    mul_b_n = mul_b_q;
    res0_n  = res0_q;
    res1_n  = res1_q;

    case (state)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_n = START;
          start_n = 1'b1;
          owner_n = gnt1;
          last_n  = gnt1;
          ack0_n  = gnt0;
          ack1_n  = gnt1;
          mul_a_n = gnt1 ? bus.a1 : bus.a0;
          mul_b_n = gnt1 ? bus.b1 : bus.b0;
        end
      end
      START: begin
        state_n = RUN;
        cnt_n   = CNT_INIT;
      end
      RUN: begin
        // Counter hits zero exactly LAT edges after the start pulse was seen by the core.
        if (cnt == 8'd0) begin
          state_n = IDLE;
          if (owner) begin
            res1_n  = bus.mul_op;
            done1_n = 1'b1;
          end else begin
            res0_n  = bus.mul_op;
            done0_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Registered copy of "state is not IDLE" so busy lines up with the state register.
    busy_n = (state_n != IDLE);
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.res0      = res0_q;
  assign bus.res1      = res1_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule
